// File: rtl/delay_timer_arbiter_pkg.sv
// Shared definitions for the delay timer arbiter: FSM state encoding and the
// default counter width.
package delay_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_CNT_BITS = 8;

endpackage

// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bundle between the requesting control blocks (master) and the
// shared delay timer (slave).
interface delay_timer_arbiter_if
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CNT_BITS = DEFAULT_CNT_BITS
);

    logic                      enable;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*CNT_BITS-1:0] delay;
    logic [N_REQ-1:0]          grant;
    logic [N_REQ-1:0]          done;
    logic                      busy;
    logic [CNT_BITS-1:0]       count;

    modport master (
        output enable, req, delay,
        input  grant, done, busy, count
    );

    modport slave (
        input  enable, req, delay,
        output grant, done, busy, count
    );

endinterface

// File: rtl/loadable_mod_counter.sv
// Modulo counter with an inclusive, loadable final value; wraps to zero when
// advanced from final_value. Clear has priority over enable.
module loadable_mod_counter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [BITS-1:0] final_value,
    output logic [BITS-1:0] Q,
    output logic            done_flag
);

    assign done_flag = (Q == final_value);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (!reset_n) begin
            Q <= '0;
        end else if (clear) begin
            Q <= '0;
        end else if (enable) begin
            Q <= done_flag ? '0 : Q + BITS'(1);
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Arbitrates N_REQ delay requests onto one shared modulo counter.
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module delay_timer_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CNT_BITS = DEFAULT_CNT_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    delay_timer_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_REQ);

    state_t              state, state_n;
    logic [IDX_W-1:0]    owner, winner, start, next_owner;
    logic [IDX_W:0]      cand;
    logic [CNT_BITS-1:0] final_reg, win_delay, cnt_q;
    logic                cnt_hit, cnt_clear, load, abort;
    logic [N_REQ-1:0]    grant_n, done_n, grant_q, done_q;
    logic                busy_q;

`ifdef ROUND_ROBIN_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    logic [IDX_W-1:0] rr_ptr;

    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= LAST_IDX;
        end else if (abort || state == DONE) begin
            rr_ptr <= owner;
        end
    end

    assign start = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + IDX_W'(1);
`else
    assign start = '0;
`endif

    // Rotated priority search: walk downwards so the candidate closest to
    // start is the last one written and therefore wins.
    always_comb begin
        winner = start;
        cand   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, start} + (IDX_W + 1)'(i);
            if (cand >= N_EXT) cand = cand - N_EXT;
            if (bus.req[cand[IDX_W-1:0]]) winner = cand[IDX_W-1:0];
        end
    end

    assign win_delay = bus.delay[winner*CNT_BITS +: CNT_BITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
        state_n = state;
        load    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    load    = 1'b1;
                    state_n = COUNT;
                end
            end
            COUNT: begin
                if (!bus.req[owner]) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (bus.enable && cnt_hit) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered with it.
    always_comb begin
        next_owner = load ? winner : owner;
        grant_n    = '0;
        done_n     = '0;
        if (state_n == COUNT) grant_n[next_owner] = 1'b1;
        if (state_n == DONE)  done_n[owner]       = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= '0;
            final_reg <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (load) begin
                owner     <= winner;
                final_reg <= win_delay;
            end
            grant_q <= grant_n;
            done_q  <= done_n;
            busy_q  <= (state_n != IDLE);
        end
    end

    // The counter sits at zero outside COUNT and is zeroed on abort; on expiry
    // it wraps to zero by itself.
    assign cnt_clear = (state != COUNT) || abort;

    loadable_mod_counter #(
        .BITS (CNT_BITS)
    ) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (cnt_clear),
        .enable      (bus.enable),
        .final_value (final_reg),
        .Q           (cnt_q),
        .done_flag   (cnt_hit)
    );

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = cnt_q;

endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
Shares one programmable modulo counter among N_REQ requesters that each need a timed delay. The block arbitrates pending requests, loads the winner's delay as the counter's inclusive final value, and runs the counter on the enable tick. It pulses a per-requester done on expiry and re-arbitrates. It sits between the control blocks that need timeouts or wait states and the single shared counter datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
CNT_BITS, 8, counter width; delay range 0..2^CNT_BITS-1, inclusive final value

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  count tick; the counter advances only in cycles where enable=1
req  input  N_REQ  per-requester request, level; must be held until done
delay  input  N_REQ*CNT_BITS  packed per-requester final values; slice i = delay[i*CNT_BITS +: CNT_BITS]
grant  output  N_REQ  one-hot owner of the counter; all zero when not counting
done  output  N_REQ  one-cycle pulse to the owner on expiry
busy  output  1  high in COUNT and DONE
count  output  CNT_BITS  current shared counter value

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset: state=IDLE; grant=0; done=0; busy=0; count=0; owner=0; final_reg=0; rr_ptr=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If |req at a clk edge: select the winner, latch owner and final_reg=delay[owner], clear count, go to COUNT.
  - grant[owner] goes high the following cycle.
  - If no request is pending, stay in IDLE.
- COUNT:
  - If req[owner]=0: abort. Go to IDLE with no done pulse, count=0, grant=0. rr_ptr still updates to owner.
  - Else if enable and count==final_reg: go to DONE.
  - Else if enable: count=count+1.
  - Else: hold.
- DONE:
  - done[owner]=1 and grant=0 for exactly one cycle.
  - rr_ptr=owner; count=0; return to IDLE.
- Latency: with enable held high, the req edge seen in IDLE at edge k gives grant from cycle k+1 and done in cycle k+D+2, where D is the delay.
  - D=0 expires on the first enabled COUNT cycle.
  - The count wraps never; final_reg caps it.
- delay is sampled only at the grant decision; later changes are ignored until the next grant.
- The requester must deassert req in the cycle done is seen. If req is still high in IDLE the cycle after DONE, it is treated as a new request.
- Simultaneous events: an abort takes priority over expiry in the same cycle.
- Minimum gap: one IDLE cycle between back-to-back grants.
- Outputs are registered; grant and done are never high together.
- Reset mid-COUNT returns everything to reset values immediately. No done pulse is issued.

Optional Feature:
Macro ROUND_ROBIN_EN.
- Defined: round-robin; the search starts at rr_ptr+1 modulo N_REQ.
- Undefined: fixed priority, lowest index wins. rr_ptr is not implemented (optimised away); all other behaviour is identical.

Decomposition:
- Package delay_timer_arbiter_pkg: FSM state encoding constants (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and a default CNT_BITS constant.
- Sub-module loadable_mod_counter:
  - Parameter BITS; ports clk, reset_n, clear, enable, final_value, Q, done_flag.
  - done_flag means Q==final_value. Clear has priority over enable.
- Arbitration (priority mask plus rotate) stays inline in the top level.

Test Plan:
- Single request: req=4'b0001, delay[0]=3, enable=1 -> grant=0001 from cycle k+1; count runs 0,1,2,3; done[0] pulses at cycle k+5; busy then falls.
- Contention, round-robin: req=4'b1111 held and re-raised after each done, all delays 1 -> service order 0,1,2,3,0 with a one-IDLE-cycle gap. With ROUND_ROBIN_EN undefined, the order is 0,0,0.
- Enable gating: delay=2, enable toggles 1,0,1,0,1 -> count holds on enable=0 cycles; done appears after the 3rd enabled COUNT cycle.
- D=0 and D=max: delay=0 -> done at cycle k+2; delay=255 (CNT_BITS=8) -> count reaches 255 without wrap; done at cycle k+257.
- Abort: req[1] dropped at count=2 of delay 10 -> next cycle grant=0, count=0, no done. A pending req[2] is granted after one IDLE cycle.
- Reset mid-operation: reset_n low at count=5 -> grant, done, busy and count are all 0 asynchronously. After release with req=0001, requester 0 is granted normally.
